// File: rtl/alu_core.sv
// alu_core: registered 32-bit integer ALU with a 64-bit result register.
// The result is computed combinationally from RA/RB/opcode and captured into RZ
// on every rising clock edge. 64-bit results hold signed products and
// remainder:quotient pairs.
module alu_core (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] RA,
   input  logic [31:0] RB,
   input  logic [4:0]  opcode,
   output logic [63:0] RZ
);

   typedef enum logic [4:0] {
      OP_ADD   = 5'b00000,
      OP_SUB   = 5'b00001,
      OP_MUL   = 5'b00010,
      OP_AND   = 5'b00011,
      OP_OR    = 5'b00100,
      OP_SHR   = 5'b00101,
      OP_SHRA  = 5'b00110,
      OP_SHL   = 5'b00111,
      OP_ROR   = 5'b01000,
      OP_ROL   = 5'b01001,
      OP_XOR   = 5'b01010,
      OP_PASSB = 5'b01011,
      OP_NEG   = 5'b01100,
      OP_DIV   = 5'b01101,
      OP_NOT   = 5'b01110,
      OP_PASSA = 5'b01111
   } op_e;

   op_e         op;
   logic [4:0]  shamt;
   logic [63:0] dbl_ra;
   logic [63:0] ror_tmp;
   logic [63:0] rol_tmp;
   logic [63:0] product;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [63:0] res_d;

   assign op     = op_e'(opcode);
   assign shamt  = RB[4:0];

   // Rotates shift a doubled copy of RA so bits wrapping past one end reappear at the other.
   assign dbl_ra  = {RA, RA};
   assign ror_tmp = dbl_ra >> shamt;
   assign rol_tmp = dbl_ra << shamt;

   // Full signed product: both operands sign-extended to 64 bits before multiplying.
   assign product = $signed({{32{RA[31]}}, RA}) * $signed({{32{RB[31]}}, RB});

   // Signed divide via unsigned magnitudes; 0x80000000 as a magnitude is exact,
   // so the overflow case (0x80000000 / -1) naturally yields 0x80000000 rem 0.
   assign a_mag = RA[31] ? (32'd0 - RA) : RA;
   assign b_mag = RB[31] ? (32'd0 - RB) : RB;
   assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
   assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
   assign quot  = (RA[31] ^ RB[31]) ? (32'd0 - q_mag) : q_mag;
   assign rem   = RA[31] ? (32'd0 - r_mag) : r_mag;

   // Select the result for the current opcode; reserved opcodes give zero.
   always_comb begin
      res_d = '0;
      case (op)
         OP_ADD:   res_d[31:0] = RA + RB;
         OP_SUB:   res_d[31:0] = RA - RB;
         OP_MUL:   res_d       = product;
         OP_AND:   res_d[31:0] = RA & RB;
         OP_OR:    res_d[31:0] = RA | RB;
         OP_SHR:   res_d[31:0] = RA >> shamt;
         OP_SHRA:  res_d[31:0] = $signed(RA) >>> shamt;
         OP_SHL:   res_d[31:0] = RA << shamt;
         OP_ROR:   res_d[31:0] = ror_tmp[31:0];
         OP_ROL:   res_d[31:0] = rol_tmp[63:32];
         OP_XOR:   res_d[31:0] = RA ^ RB;
         OP_PASSB: res_d[31:0] = RB;
         OP_NEG:   res_d[31:0] = 32'd0 - RA;
         OP_DIV: begin
            if (RB == 32'd0) begin
               res_d = {RA, 32'hFFFF_FFFF};
            end else begin
               res_d = {rem, quot};
            end
         end
         OP_NOT:   res_d[31:0] = ~RA;
         OP_PASSA: res_d[31:0] = RA;
         default:  res_d       = '0;
      endcase
   end

   // Result register; clear asynchronously forces it to zero.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         RZ <= '0;
      end else begin
         RZ <= res_d;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core. Stimulus pushes the expected
// result for each issued op; a monitor pops and compares after each edge.
module tb_alu_core;

   logic        clock;
   logic        clear;
   logic [31:0] RA;
   logic [31:0] RB;
   logic [4:0]  opcode;
   logic [63:0] RZ;

   typedef struct {
      logic [63:0] exp;
      string       name;
   } sb_t;

   sb_t sbq[$];
   int  checks = 0;
   int  errors = 0;

   alu_core dut (
      .clock  (clock),
      .clear  (clear),
      .RA     (RA),
      .RB     (RB),
      .opcode (opcode),
      .RZ     (RZ)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model, written independently in wide integer arithmetic.
   function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      q;
      longint      rm;
      logic [31:0] r;
      int unsigned sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      r  = a;
      case (op)
         5'd0:  return {32'h0, a + b};
         5'd1:  return {32'h0, a - b};
         5'd2:  return 64'(sa * sb);
         5'd3:  return {32'h0, a & b};
         5'd4:  return {32'h0, a | b};
         5'd5:  return {32'h0, a >> sh};
         5'd6: begin
            for (int k = 0; k < int'(sh); k++) r = {r[31], r[31:1]};
            return {32'h0, r};
         end
         5'd7:  return {32'h0, a << sh};
         5'd8: begin
            for (int k = 0; k < int'(sh); k++) r = {r[0], r[31:1]};
            return {32'h0, r};
         end
         5'd9: begin
            for (int k = 0; k < int'(sh); k++) r = {r[30:0], r[31]};
            return {32'h0, r};
         end
         5'd10: return {32'h0, a ^ b};
         5'd11: return {32'h0, b};
         5'd12: return {32'h0, 32'd0 - a};
         5'd13: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q  = sa / sb;
            rm = sa % sb;
            return {rm[31:0], q[31:0]};
         end
         5'd14: return {32'h0, ~a};
         5'd15: return {32'h0, a};
         default: return 64'h0;
      endcase
   endfunction

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
      sb_t e;
      @(negedge clock);
      opcode = op;
      RA     = a;
      RB     = b;
      e.exp  = exp;
      e.name = name;
      sbq.push_back(e);
   endtask

   // Monitor: one result per edge for every op issued before that edge.
   initial begin
      sb_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.name, RZ, e.exp);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic pulse_clear(input string name);
      @(negedge clock);
      clear = 1'b0;
      #1;
      check({name, "_async"}, RZ, 64'h0);
      @(posedge clock);
      #1;
      check({name, "_hold"}, RZ, 64'h0);
      @(negedge clock);
      clear = 1'b1;
   endtask

   initial begin
      sb_t e;
      logic [4:0]  rop;
      logic [31:0] ra_r;
      logic [31:0] rb_r;
      clear  = 1'b1;
      opcode = 5'b00000;
      RA     = 32'd8;
      RB     = 32'd8;
      #1;
      clear = 1'b0;
      #1;
      check("reset_async", RZ, 64'h0);
      @(posedge clock);
      #1;
      check("reset_hold", RZ, 64'h0);
      @(negedge clock);
      clear  = 1'b1;
      e.exp  = 64'h0000_0000_0000_0010;
      e.name = "first_add";
      sbq.push_back(e);

      issue(5'b00010, 32'd16,          32'd8,           64'h0000_0000_0000_0080, "mul_pp");
      issue(5'b00010, 32'hFFFF_FFF8,   32'd8,           64'hFFFF_FFFF_FFFF_FFC0, "mul_np");
      issue(5'b00010, 32'd8,           32'hFFFF_FFF8,   64'hFFFF_FFFF_FFFF_FFC0, "mul_pn");
      issue(5'b00010, 32'hFFFF_FFF8,   32'hFFFF_FFF8,   64'h0000_0000_0000_0040, "mul_nn");
      issue(5'b00010, 32'h8000_0000,   32'h8000_0000,   64'h4000_0000_0000_0000, "mul_min");
      issue(5'b01101, 32'hFFFF_FFF8,   32'hFFFF_FFF8,   64'h0000_0000_0000_0001, "div_nn");
      issue(5'b01101, 32'hFFFF_FFF9,   32'd2,           64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
      issue(5'b01101, 32'd5,           32'd0,           64'h0000_0005_FFFF_FFFF, "div_by0");
      issue(5'b01101, 32'h8000_0000,   32'hFFFF_FFFF,   64'h0000_0000_8000_0000, "div_ovf");
      issue(5'b01101, 32'd7,           32'hFFFF_FFFE,   64'h0000_0001_FFFF_FFFD, "div_7_m2");
      issue(5'b01100, 32'd6,           32'd99,          64'h0000_0000_FFFF_FFFA, "neg_6");
      issue(5'b01100, 32'h8000_0000,   32'd0,           64'h0000_0000_8000_0000, "neg_min");
      issue(5'b00101, 32'h8000_0001,   32'd1,           64'h0000_0000_4000_0000, "shr_1");
      issue(5'b00110, 32'h8000_0001,   32'd1,           64'h0000_0000_C000_0000, "shra_1");
      issue(5'b00111, 32'h8000_0001,   32'd1,           64'h0000_0000_0000_0002, "shl_1");
      issue(5'b01000, 32'h8000_0001,   32'd1,           64'h0000_0000_C000_0000, "ror_1");
      issue(5'b01001, 32'h8000_0001,   32'd1,           64'h0000_0000_0000_0003, "rol_1");
      for (int unsigned k = 5; k <= 9; k++) begin
         issue(5'(k), 32'h8000_0001, 32'd32, 64'h0000_0000_8000_0001, $sformatf("shift32_op%0d", k));
      end
      issue(5'b00110, 32'h8000_0000,   32'd31,          64'h0000_0000_FFFF_FFFF, "shra_31");
      issue(5'b00011, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0000_0000_00F0_00F0, "and");
      issue(5'b00100, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0000_0000_FFF0_FFF0, "or");
      issue(5'b01010, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0000_0000_FF00_FF00, "xor");
      issue(5'b01110, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0000_0000_0F0F_0F0F, "not");
      issue(5'b01011, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0000_0000_0FF0_0FF0, "passb");
      issue(5'b01111, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0000_0000_F0F0_F0F0, "passa");
      issue(5'b00001, 32'd3,           32'd5,           64'h0000_0000_FFFF_FFFE, "sub_3_5");
      issue(5'b00000, 32'hFFFF_FFFF,   32'd1,           64'h0000_0000_0000_0000, "add_wrap");
      issue(5'b10101, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0,                   "reserved");
      issue(5'b10101, 32'hF0F0_F0F0,   32'h0FF0_0FF0,   64'h0,                   "reserved_hold");

      for (int i = 0; i < 1200; i++) begin
         if (i == 600) pulse_clear("mid_clear");
         rop  = 5'($urandom_range(0, 31));
         ra_r = $urandom;
         rb_r = $urandom;
         case ($urandom_range(0, 7))
            0: rb_r = 32'd0;
            1: rb_r = $urandom_range(0, 40);
            2: ra_r = 32'h8000_0000;
            default: ;
         endcase
         issue(rop, ra_r, rb_r, model(rop, ra_r, rb_r), $sformatf("rand%0d_op%0d", i, rop));
      end

      @(negedge clock);
      @(negedge clock);
      check("scoreboard_drained", 64'(sbq.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
